mode_drive_scatter: RTL and testbench

- Inverse of the mode-projection dot product in the mechanical resonator model: it scatters one scalar drive sample (e.g. piezo force) onto every mechanical mode.
- Once per frame it latches a scalar `x` and walks an external coupling-coefficient memory.
- It streams `y[n] = sat(x*k[n])` for `n = 0..n_modes-1`, one slot per clock, into the time-multiplexed resonator.

---
 rtl/rtsim_pkg.sv | 39 +++
 rtl/mode_drive_scatter_if.sv | 33 +++
 rtl/sat_mul_stage.sv | 91 +++++++++
 rtl/mode_drive_scatter.sv | 84 ++++++++
 tb/tb_mode_drive_scatter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtsim_pkg.sv
// rtsim_pkg: shared definitions for the resonator simulation datapath.
//   DW         - width of drive samples, coefficients and per-mode results
//   PROD_SHIFT - right shift applied to the full-width product
//   state_e    - frame sequencer states
//   sat_shift  - shifts a DW x DW product back to DW bits and clips it,
//                shared with the mode-projection (dot-product) side
package rtsim_pkg;

  localparam int DW         = 18;
  localparam int PROD_SHIFT = 17;
  localparam int PW         = 2 * DW;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DW-1:0] value;
    logic          clipped;
  } sat_t;

  // The product's top DW+1 bits are the floored shift result; when the two
  // MSBs of that field disagree the value does not fit in DW bits and is
  // clipped towards the sign of the product.
  function automatic sat_t sat_shift(input logic signed [PW-1:0] prod);
    sat_t       r;
    logic [DW:0] sh;
    sh        = prod[PW-1:PROD_SHIFT];
    r.clipped = sh[DW] ^ sh[DW-1];
    if (!r.clipped) begin
      r.value = sh[DW-1:0];
    end else begin
      r.value = {sh[DW], {(DW-1){~sh[DW]}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/mode_drive_scatter_if.sv
// mode_drive_scatter_if: frame/coefficient/result bundle of the drive scatter.
//   start, x            - frame sync pulse and scalar drive sample
//   k_in, k_in_addr     - coefficient memory data (one clock after address) and address
//   result, valid, slot - per-mode drive stream, its qualifier and mode index
//   sat                 - current valid slot was clipped
//   busy                - frame in progress or pipeline not yet empty
// The slave modport is the scatter engine; master is whoever drives it.
interface mode_drive_scatter_if #(
  parameter int pcw = 10
);
  import rtsim_pkg::*;

  logic                 start;
  logic signed [DW-1:0] x;
  logic signed [DW-1:0] k_in;
  logic [pcw-1:0]       k_in_addr;
  logic signed [DW-1:0] result;
  logic                 valid;
  logic [pcw-1:0]       slot;
  logic                 sat;
  logic                 busy;

  modport slave (
    input  start, x, k_in,
    output k_in_addr, result, valid, slot, sat, busy
  );

  modport master (
    output start, x, k_in,
    input  k_in_addr, result, valid, slot, sat, busy
  );

endinterface

// File: rtl/sat_mul_stage.sv
// sat_mul_stage: four registered stages turning a coefficient stream into
// saturated per-mode drive values, with valid/slot tags riding alongside.
//   clk, rst     - clock, synchronous active-high reset
//   flush_i      - drop every in-flight tag (frame restart)
//   in_valid_i   - tag for the coefficient arriving on k_i this cycle
//   in_slot_i    - mode index for that coefficient
//   k_i, x_i     - coefficient and held scalar drive
//   out_valid_o, out_slot_o, result_o, sat_o - registered output slot
//   any_valid_o  - some tag is still inside this pipeline
module sat_mul_stage
  import rtsim_pkg::*;
#(
  parameter int pcw = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  input  logic [pcw-1:0]       in_slot_i,
  input  logic signed [DW-1:0] k_i,
  input  logic signed [DW-1:0] x_i,
  output logic                 out_valid_o,
  output logic [pcw-1:0]       out_slot_o,
  output logic signed [DW-1:0] result_o,
  output logic                 sat_o,
  output logic                 any_valid_o
);

  logic                 v1_q, v2_q, v3_q, v4_q;
  logic [pcw-1:0]       s1_q, s2_q, s3_q, s4_q;
  logic signed [DW-1:0] k1_q;
  logic signed [PW-1:0] prod2_q;
  sat_t                 sh3_q;
  logic signed [DW-1:0] result4_q;
  logic                 sat4_q;

  // A restart kills every tag at once, including the one entering the
  // output register, so the old frame stops cleanly.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
    end else begin
      v1_q <= in_valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
    end
  end

  // Data stages run freely; only the tags decide what reaches the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      k1_q    <= '0;
      prod2_q <= '0;
      sh3_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
    end else begin
      k1_q    <= k_i;
      s1_q    <= in_slot_i;
      prod2_q <= k1_q * x_i;
      s2_q    <= s1_q;
      sh3_q   <= sat_shift(prod2_q);
      s3_q    <= s2_q;
    end
  end

  // Result and slot hold their last value between slots; sat only ever
  // reports on a slot that is actually being presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      result4_q <= '0;
      s4_q      <= '0;
      sat4_q    <= 1'b0;
    end else begin
      sat4_q <= v3_q & ~flush_i & sh3_q.clipped;
      if (v3_q && !flush_i) begin
        result4_q <= $signed(sh3_q.value);
        s4_q      <= s3_q;
      end
    end
  end

  assign out_valid_o = v4_q;
  assign out_slot_o  = s4_q;
  assign result_o    = result4_q;
  assign sat_o       = sat4_q;
  assign any_valid_o = v1_q | v2_q | v3_q | v4_q;

endmodule

// File: rtl/mode_drive_scatter.sv
// mode_drive_scatter: once per frame latches a scalar drive x and streams
// sat(x*k[n]) for every mode n = 0..n_modes-1, one slot per clock.
//   clk, rst - clock, synchronous active-high reset (overrides start)
//   bus      - slave side of mode_drive_scatter_if (start/x in, coefficient
//              address out / data in, result/valid/slot/sat/busy out)
// Parameters: pcw = coefficient address width, n_modes = slots per frame
// (1..2^pcw).
module mode_drive_scatter
  import rtsim_pkg::*;
#(
  parameter int pcw     = 10,
  parameter int n_modes = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mode_drive_scatter_if.slave  bus
);

  localparam logic [pcw-1:0] LastAddr = pcw'(n_modes - 1);

  state_e               state_q, state_d;
  logic [pcw-1:0]       pc_q, pc_d;
  logic signed [DW-1:0] x_hold_q, x_hold_d;
  logic                 v0_q;
  logic [pcw-1:0]       s0_q;
  logic                 pipe_busy;

  // v0/s0 delay the issue tag by the memory's one-clock read latency so it
  // lines up with k_in. A start drops the address issued in its own cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      x_hold_q <= '0;
      v0_q     <= 1'b0;
      s0_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      x_hold_q <= x_hold_d;
      v0_q     <= (state_q == RUN) && !bus.start;
      s0_q     <= pc_q;
    end
  end

  // A start always (re)opens a frame; otherwise RUN walks the addresses and
  // falls back to IDLE after the last one, where pc simply holds.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    x_hold_d = x_hold_q;
    if (bus.start) begin
      state_d  = RUN;
      pc_d     = '0;
      x_hold_d = bus.x;
    end else if (state_q == RUN) begin
      pc_d = pc_q + 1'b1;
      if (pc_q == LastAddr) begin
        state_d = IDLE;
      end
    end
  end

  sat_mul_stage #(
    .pcw (pcw)
  ) u_mul (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.start),
    .in_valid_i  (v0_q),
    .in_slot_i   (s0_q),
    .k_i         (bus.k_in),
    .x_i         (x_hold_q),
    .out_valid_o (bus.valid),
    .out_slot_o  (bus.slot),
    .result_o    (bus.result),
    .sat_o       (bus.sat),
    .any_valid_o (pipe_busy)
  );

  assign bus.k_in_addr = pc_q;
  assign bus.busy      = (state_q == RUN) | v0_q | pipe_busy;

endmodule

// File: tb/tb_mode_drive_scatter.sv
// tb_mode_drive_scatter: two scatter instances (8 modes on a 10-bit address,
// 16 modes on a full 4-bit address) driven by directed frames and random
// traffic, checked every cycle against a frame-level reference model.
module tb_mode_drive_scatter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  mode_drive_scatter_if #(.pcw(10)) busA ();
  mode_drive_scatter_if #(.pcw(4))  busB ();

  logic signed [17:0] memA [0:1023];
  logic signed [17:0] memB [0:15];

  mode_drive_scatter #(.pcw(10), .n_modes(8)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  mode_drive_scatter #(.pcw(4), .n_modes(16)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  always #5 clk = ~clk;

  // Coefficient memories with one clock of read latency.
  always @(posedge clk) begin
    busA.k_in <= memA[busA.k_in_addr];
    busB.k_in <= memB[busB.k_in_addr];
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit sa, input int xa, input bit sb, input int xb);
    @(negedge clk);
    rst        = r;
    busA.start = sa;
    busA.x     = 18'(xa);
    busB.start = sb;
    busB.x     = 18'(xb);
  endtask

  function automatic int rand18();
    logic [17:0] r;
    r = 18'($urandom);
    if ($urandom_range(0, 7) == 0) r = 18'h20000;
    else if ($urandom_range(0, 7) == 0) r = 18'h1FFFF;
    return int'($signed(r));
  endfunction

  // Reference model: a frame started at edge E presents slot n right after
  // edge E+5+n, unless a later start or a reset has happened since. The
  // address counter runs from 0 for n_modes cycles and then holds.
  int     nm [2]   = '{8, 16};
  int     mask [2] = '{1023, 15};
  int     lastStart [2];
  int     startX [2];
  longint lastRes [2];
  bit     haveReset = 1'b0;
  bit     stIn [2];
  int     xIn [2];
  longint actV [2], actS [2], actR [2], actSat [2], actB [2], actA [2];
  int     d, kv;
  longint prodM, q, expRes, expAddr;
  bit     expV, expSat, expBusy;

  always begin : compareProc
    @(posedge clk);
    cyc++;
    stIn[0] = busA.start;
    stIn[1] = busB.start;
    xIn[0]  = int'(busA.x);
    xIn[1]  = int'(busB.x);
    if (rst) begin
      haveReset = 1'b1;
      for (int i = 0; i < 2; i++) begin
        lastStart[i] = -1;
        lastRes[i]   = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stIn[i]) begin
          lastStart[i] = cyc;
          startX[i]    = xIn[i];
        end
      end
    end
    #1;
    actV[0] = busA.valid;  actV[1] = busB.valid;
    actS[0] = busA.slot;   actS[1] = busB.slot;
    actR[0] = busA.result; actR[1] = busB.result;
    actSat[0] = busA.sat;  actSat[1] = busB.sat;
    actB[0] = busA.busy;   actB[1] = busB.busy;
    actA[0] = busA.k_in_addr; actA[1] = busB.k_in_addr;
    if (haveReset) begin
      for (int i = 0; i < 2; i++) begin
        d      = cyc - lastStart[i];
        expV   = (lastStart[i] >= 0) && (d >= 5) && (d - 5 < nm[i]);
        expSat = 1'b0;
        expRes = lastRes[i];
        if (expV) begin
          kv    = (i == 0) ? int'(memA[d-5]) : int'(memB[d-5]);
          prodM = longint'(startX[i]) * longint'(kv);
          q     = prodM >>> 17;
          if (q > 131071) begin
            q = 131071;
            expSat = 1'b1;
          end else if (q < -131072) begin
            q = -131072;
            expSat = 1'b1;
          end
          expRes     = q;
          lastRes[i] = q;
        end
        expBusy = (lastStart[i] >= 0) && (d <= nm[i] + 4);
        expAddr = (lastStart[i] < 0) ? 0 : (((d < nm[i]) ? d : nm[i]) & mask[i]);
        checkOutput((i == 0) ? "valid_A" : "valid_B", actV[i], longint'(expV));
        if (expV) checkOutput((i == 0) ? "slot_A" : "slot_B", actS[i], longint'(d - 5));
        checkOutput((i == 0) ? "result_A" : "result_B", actR[i], expRes);
        checkOutput((i == 0) ? "sat_A" : "sat_B", actSat[i], longint'(expSat));
        checkOutput((i == 0) ? "busy_A" : "busy_B", actB[i], longint'(expBusy));
        checkOutput((i == 0) ? "addr_A" : "addr_B", actA[i], expAddr);
      end
    end
  end

  // One 8-mode frame on instance A with hand-computed expectations.
  task automatic runFrameA(input string tag, input int xv, input int er[8], input int es[8]);
    applyStimulus(1'b0, 1'b1, xv, 1'b0, 0);
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
      @(posedge clk);
      #2;
      if (c >= 5 && c <= 12) begin
        checkOutput({tag, "_valid"}, busA.valid, 1);
        checkOutput({tag, "_slot"}, busA.slot, c - 5);
        checkOutput({tag, "_result"}, busA.result, er[c-5]);
        checkOutput({tag, "_sat"}, busA.sat, es[c-5]);
      end else begin
        checkOutput({tag, "_valid"}, busA.valid, 0);
      end
      if (c == 12) checkOutput({tag, "_busy_last"}, busA.busy, 1);
      if (c == 13) checkOutput({tag, "_busy_drop"}, busA.busy, 0);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int er[8];
    int es[8];
    rst        = 1'b1;
    busA.start = 1'b0;
    busA.x     = '0;
    busB.start = 1'b0;
    busB.x     = '0;
    for (int n = 0; n < 1024; n++) memA[n] = '0;
    for (int n = 0; n < 16; n++) memB[n] = '0;

    // Reset with random start/x, which reset must override.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), rand18(), 1'($urandom_range(0, 1)), rand18());
      @(posedge clk);
      #2;
      checkOutput("rst_valid", busA.valid, 0);
      checkOutput("rst_result", busA.result, 0);
      checkOutput("rst_busy", busA.busy, 0);
      checkOutput("rst_addr", busA.k_in_addr, 0);
      checkOutput("rst_busy_B", busB.busy, 0);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
      @(posedge clk);
      #2;
      checkOutput("idle_valid", busA.valid, 0);
      checkOutput("idle_valid_B", busB.valid, 0);
    end

    // Basic frame: k[n] = 4n, x = 65536 gives 2n.
    for (int n = 0; n < 8; n++) begin
      memA[n] = 18'(4 * n);
      er[n]   = 2 * n;
      es[n]   = 0;
    end
    runFrameA("basic", 65536, er, es);

    // Sign and floor behaviour of the shift.
    memA[0] = 18'sd1;
    memA[1] = -18'sd1;
    memA[2] = 18'sd65536;
    memA[3] = -18'sd65537;
    for (int n = 4; n < 8; n++) memA[n] = '0;
    er = '{-1, 0, -2, 1, 0, 0, 0, 0};
    es = '{0, 0, 0, 0, 0, 0, 0, 0};
    runFrameA("sign", -3, er, es);

    // The single overflowing pair, next to a non-overflowing extreme.
    memA[0] = -18'sd131072;
    memA[1] = 18'sd131071;
    for (int n = 2; n < 8; n++) memA[n] = '0;
    er = '{131071, -131071, 0, 0, 0, 0, 0, 0};
    es = '{1, 0, 0, 0, 0, 0, 0, 0};
    runFrameA("satur", -131072, er, es);

    // Restart three cycles into a frame: the first frame never shows a slot.
    for (int n = 0; n < 8; n++) memA[n] = 18'(4 * n);
    applyStimulus(1'b0, 1'b1, 65536, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 32768, 1'b0, 0);
    for (int c = 1; c <= 13; c++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
      @(posedge clk);
      #2;
      if (c >= 5 && c <= 12) begin
        checkOutput("restart_valid", busA.valid, 1);
        checkOutput("restart_slot", busA.slot, c - 5);
        checkOutput("restart_result", busA.result, c - 5);
      end else begin
        checkOutput("restart_valid", busA.valid, 0);
      end
    end

    // Full address range on instance B: one complete frame, then starts
    // every 16 cycles, which truncate the tail of each previous frame.
    for (int n = 0; n < 16; n++) memB[n] = 18'(rand18());
    applyStimulus(1'b0, 1'b0, 0, 1'b1, rand18());
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
      @(posedge clk);
      #2;
      if (c >= 5) begin
        checkOutput("full_valid", busB.valid, 1);
        checkOutput("full_slot", busB.slot, c - 5);
      end
      if (c == 15) checkOutput("full_addr_last", busB.k_in_addr, 15);
      if (c == 16) checkOutput("full_addr_wrap", busB.k_in_addr, 0);
      if (c == 20) checkOutput("full_addr_hold", busB.k_in_addr, 0);
    end
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b1, rand18());
      repeat (15) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    end
    repeat (25) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);

    // Random traffic: frequent restarts, occasional resets, extreme values.
    for (int n = 0; n < 8; n++) memA[n] = 18'(rand18());
    for (int n = 0; n < 16; n++) memB[n] = 18'(rand18());
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 249) == 0), 1'($urandom_range(0, 9) == 0), rand18(),
                    1'($urandom_range(0, 13) == 0), rand18());
    end
    repeat (30) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
